// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
// Programmable interrupt source for the CPU IRQ/IRW interface. Each channel
// has a down-counting timer. Every timer event becomes a level request on IRQ
// that is held until the CPU acknowledges it on IRW.
//
// Ports:
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   we/addr/wdata single-cycle register write port
//   rdata         combinational read data for addr
//   IRW           per-channel acknowledge / in-service from the CPU
//   IRQ           per-channel interrupt request (decoded from state flops)
//   ovf           sticky overflow flags, mirror of STATUS[2*N_IRQ-1:N_IRQ]
//
// Register map (word address):
//   0x0 CTRL      [N-1:0] enable, [2N-1:N] oneshot
//   0x1 STATUS    [N-1:0] pending (RO), [2N-1:N] ovf (W1C)
//   0x2 SWTRIG    write-only software trigger, only when IRQ_SWTRIG_EN is defined
//   0x4+i PERIOD  read/write, a write also loads COUNT
//   0x8+i COUNT   read-only
//
// Build option: define IRQ_SWTRIG_EN to add the SWTRIG register.
//
// Request state machine, one per channel:
//   state   | meaning
//   IDLE    | no request outstanding
//   REQ     | IRQ high, waiting for IRW
//   ACK     | CPU servicing (IRW high); new events go to pending

module irq_source_ctrl #(
    parameter int WIDTH = 32,
    parameter int N_IRQ = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [N_IRQ-1:0] IRW,
    output logic [N_IRQ-1:0] IRQ,
    output logic [N_IRQ-1:0] ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [N_IRQ-1:0] en_q, en_d;
    logic [N_IRQ-1:0] oneshot_q, oneshot_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] period_q [N_IRQ];
    logic [WIDTH-1:0] period_d [N_IRQ];
    logic [WIDTH-1:0] count_q  [N_IRQ];
    logic [WIDTH-1:0] count_d  [N_IRQ];
    state_t           state_q  [N_IRQ];
    state_t           state_d  [N_IRQ];

    logic [N_IRQ-1:0] tmr_ev;
    logic [N_IRQ-1:0] ev;
    logic [N_IRQ-1:0] ovf_set;
    logic             wr_ctrl;
    logic             wr_status;

    assign wr_ctrl   = we && (addr == 4'h0);
    assign wr_status = we && (addr == 4'h1);

    // Timer events; a software trigger joins the request path but does not
    // touch the counter or the oneshot enable clear.
    always_comb begin
        tmr_ev = '0;
        ev     = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            tmr_ev[i] = en_q[i] && (period_q[i] != '0) && (count_q[i] == WIDTH'(1));
            ev[i]     = tmr_ev[i];
`ifdef IRQ_SWTRIG_EN
            if (we && (addr == 4'h2) && wdata[i]) begin
                ev[i] = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        pending_d = pending_q;
        ovf_set   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
            state_d[i]  = state_q[i];

            if (en_q[i] && (period_q[i] != '0)) begin
                count_d[i] = tmr_ev[i] ? period_q[i] : count_q[i] - WIDTH'(1);
            end
            if (tmr_ev[i] && oneshot_q[i]) begin
                en_d[i] = 1'b0;
            end

            case (state_q[i])
                ST_IDLE: begin
                    if (ev[i]) begin
                        state_d[i] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IRW[i]) begin
                        state_d[i] = ST_ACK;
                        // an event racing the acknowledge is kept, not lost
                        if (ev[i]) begin
                            pending_d[i] = 1'b1;
                        end
                    end else if (ev[i]) begin
                        ovf_set[i] = 1'b1;
                    end
                end
                ST_ACK: begin
                    if (ev[i] && pending_q[i]) begin
                        ovf_set[i] = 1'b1;
                    end
                    if (IRW[i]) begin
                        pending_d[i] = pending_q[i] | ev[i];
                    end else if (pending_q[i] || ev[i]) begin
                        state_d[i]   = ST_REQ;
                        pending_d[i] = 1'b0;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            // CPU writes override counter activity in the same cycle
            if (we && (addr == 4'(4 + i))) begin
                period_d[i] = wdata;
                count_d[i]  = wdata;
            end
            if (wr_ctrl && wdata[i] && !en_q[i]) begin
                count_d[i] = period_q[i];
            end
        end

        if (wr_ctrl) begin
            en_d      = wdata[N_IRQ-1:0];
            oneshot_d = wdata[2*N_IRQ-1:N_IRQ];
        end

        // a new overflow beats a W1C in the same cycle
        ovf_d = ovf_q;
        if (wr_status) begin
            ovf_d = ovf_q & ~wdata[2*N_IRQ-1:N_IRQ];
        end
        ovf_d = ovf_d | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= '0;
            oneshot_q <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
                state_q[i]  <= ST_IDLE;
            end
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < N_IRQ; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    always_comb begin
        IRQ = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            IRQ[i] = (state_q[i] == ST_REQ);
        end
    end

    assign ovf = ovf_q;

    always_comb begin
        rdata = '0;
        case (addr)
            4'h0: rdata[2*N_IRQ-1:0] = {oneshot_q, en_q};
            4'h1: rdata[2*N_IRQ-1:0] = {ovf_q, pending_q};
            default: begin
                for (int i = 0; i < N_IRQ; i++) begin
                    if (addr == 4'(4 + i)) begin
                        rdata = period_q[i];
                    end
                    if (addr == 4'(8 + i)) begin
                        rdata = count_q[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;

    localparam int W = 32;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we = 1'b0;
    logic [3:0]   addr = 4'h0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic [N-1:0] IRW = '0;
    logic [N-1:0] IRQ;
    logic [N-1:0] ovf;

    int n_tests = 0;
    int n_fail  = 0;

    irq_source_ctrl #(.WIDTH(W), .N_IRQ(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .IRW  (IRW),
        .IRQ  (IRQ),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: request life expressed as "irq line up" and
    // "cpu busy servicing" booleans plus pending/overflow flags.
    bit [N-1:0]   m_en, m_oneshot, m_irq, m_busy, m_pend, m_ovf;
    logic [W-1:0] m_period [N];
    logic [W-1:0] m_count  [N];

    task automatic model_reset();
        m_en = '0; m_oneshot = '0; m_irq = '0; m_busy = '0; m_pend = '0; m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            m_period[i] = '0;
            m_count[i]  = '0;
        end
    endtask

    task automatic model_step();
        bit [N-1:0] old_en = m_en;
        bit [N-1:0] en_next = m_en;
        bit [N-1:0] set_ovf = '0;
        for (int i = 0; i < N; i++) begin
            bit ev = 1'b0;
            if (m_en[i] && m_period[i] != 0) begin
                if (m_count[i] == 1) begin
                    ev = 1'b1;
                    m_count[i] = m_period[i];
                    if (m_oneshot[i]) en_next[i] = 1'b0;
                end else begin
                    m_count[i] = m_count[i] - 1;
                end
            end
`ifdef IRQ_SWTRIG_EN
            if (we && addr == 4'h2 && wdata[i]) ev = 1'b1;
`endif
            if (m_irq[i]) begin
                if (IRW[i]) begin
                    m_irq[i] = 1'b0;
                    m_busy[i] = 1'b1;
                    if (ev) m_pend[i] = 1'b1;
                end else if (ev) begin
                    set_ovf[i] = 1'b1;
                end
            end else if (m_busy[i]) begin
                if (ev) begin
                    if (m_pend[i]) set_ovf[i] = 1'b1;
                    else m_pend[i] = 1'b1;
                end
                if (!IRW[i]) begin
                    m_busy[i] = 1'b0;
                    if (m_pend[i]) begin
                        m_irq[i] = 1'b1;
                        m_pend[i] = 1'b0;
                    end
                end
            end else if (ev) begin
                m_irq[i] = 1'b1;
            end
        end
        m_en = en_next;
        if (we) begin
            if (addr == 4'h0) begin
                for (int i = 0; i < N; i++)
                    if (wdata[i] && !old_en[i]) m_count[i] = m_period[i];
                m_en      = wdata[N-1:0];
                m_oneshot = wdata[2*N-1:N];
            end
            if (addr == 4'h1) m_ovf = m_ovf & ~wdata[2*N-1:N];
            for (int i = 0; i < N; i++) begin
                if (int'(addr) == 4 + i) begin
                    m_period[i] = wdata;
                    m_count[i]  = wdata;
                end
            end
        end
        m_ovf = m_ovf | set_ovf;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    function automatic logic [W-1:0] model_read(input logic [3:0] a);
        logic [W-1:0] r = '0;
        if (a == 4'h0) r = W'({m_oneshot, m_en});
        else if (a == 4'h1) r = W'({m_ovf, m_pend});
        else begin
            for (int i = 0; i < N; i++) begin
                if (int'(a) == 4 + i) r = m_period[i];
                if (int'(a) == 8 + i) r = m_count[i];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_irq",   W'(IRQ), W'(m_irq));
        check("model_ovf",   W'(ovf), W'(m_ovf));
        check("model_rdata", rdata,   model_read(addr));
    endtask

    // one clock; inputs are changed only right after the negedge compare
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0; wdata = '0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [W-1:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_irq", W'(IRQ), 0);
        check("reset_ovf", W'(ovf), 0);
        rd_check("reset_ctrl", 4'h0, 0);
        rst = 1'b0;
        step();

        // periodic channel 0, period 5
        wr(4'h4, 5);
        wr(4'h0, 32'h1);
        repeat (4) step();
        check("periodic_before", W'(IRQ[0]), 0);
        step();
        check("periodic_first", W'(IRQ[0]), 1);
        repeat (5) step();
        check("periodic_ovf", W'(ovf[0]), 1);
        rd_check("periodic_status", 4'h1, 32'h8);
        wr(4'h0, 0);
        wr(4'h1, 32'h8);
        IRW = 3'b001; step();
        IRW = 3'b000; step();
        check("periodic_cleared", W'({IRQ[0], ovf[0]}), 0);

        // handshake on channel 1
        wr(4'h5, 3);
        wr(4'h0, 32'h2);
        repeat (3) step();
        check("hs_irq_up", W'(IRQ[1]), 1);
        wr(4'h0, 0);
        IRW = 3'b010;
        step();
        check("hs_irq_drop", W'(IRQ[1]), 0);
        repeat (2) step();
        IRW = 3'b000;
        step();
        check("hs_irq_stays_low", W'(IRQ[1]), 0);
        rd_check("hs_status", 4'h1, 0);

        // pending during acknowledge on channel 2
        wr(4'h6, 4);
        wr(4'h0, 32'h4);
        repeat (4) step();
        check("pend_irq_up", W'(IRQ[2]), 1);
        IRW = 3'b100;
        repeat (6) step();
        check("pend_irq_low", W'(IRQ[2]), 0);
        rd_check("pend_set", 4'h1, 32'h4);
        IRW = 3'b000;
        step();
        check("pend_reassert", W'(IRQ[2]), 1);
        rd_check("pend_cleared", 4'h1, 0);
        wr(4'h0, 0);
        IRW = 3'b100; step();
        IRW = 3'b000; step();
        wr(4'h1, 32'h38);

        // oneshot on channel 0
        wr(4'h4, 3);
        wr(4'h0, 32'h9);
        repeat (3) step();
        check("oneshot_irq", W'(IRQ[0]), 1);
        rd_check("oneshot_ctrl", 4'h0, 32'h8);
        rd_check("oneshot_count", 4'h8, 3);
        repeat (6) step();
        rd_check("oneshot_frozen", 4'h8, 3);
        check("oneshot_no_ovf", W'(ovf[0]), 0);
        IRW = 3'b001; step();
        IRW = 3'b000; step();
        wr(4'h0, 0);

        // software trigger
        wr(4'h2, 32'h4);
`ifdef IRQ_SWTRIG_EN
        check("swtrig_irq", W'(IRQ[2]), 1);
`else
        check("swtrig_absent", W'(IRQ[2]), 0);
`endif
        rd_check("swtrig_read", 4'h2, 0);
        IRW = 3'b100; step();
        IRW = 3'b000; step();

        // reset mid-operation
        wr(4'h4, 2);
        wr(4'h0, 32'h1);
        repeat (6) step();
        addr = 4'h1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_irq", W'(IRQ), 0);
        check("rst_ovf", W'(ovf), 0);
        check("rst_rdata", rdata, 0);
        step();
        rst = 1'b0;
        step();
        rd_check("rst_count0", 4'h8, 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int a = $urandom_range(0, 15);
            we   = ($urandom_range(0, 3) == 0);
            addr = 4'(a);
            if (a >= 4 && a <= 7) wdata = W'($urandom_range(0, 6));
            else if (a == 0)      wdata = W'($urandom_range(0, 63));
            else                  wdata = W'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) IRW[i] = ~IRW[i];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
